// File: rtl/rom_lector.sv
// rom_lector: sequential read controller placed in front of the synchronous ROM (srom).
// A start pulse sweeps an address window (wrapping at DEPTH), captures the words the
// ROM returns one cycle later, and streams them out over valid/ready with a running sum.
//
// Ports:
//   clk, rst_n        clock / asynchronous active-low reset
//   inicio            start pulse, honoured only while ocupado=0
//   dir_inicio        first address of the sweep
//   longitud          number of words to read (0..255)
//   direccion         registered address to the ROM
//   dato_rom          ROM read data, valid one cycle after direccion is sampled
//   dato_out, valido  output stream (held stable while stalled)
//   listo             stream ready from the consumer
//   ocupado           high from the accepted start until the sweep ends
//   fin               one-cycle end-of-sweep pulse
//   suma              sum of beats transferred in the current sweep
//   error             sticky: dir_inicio was outside 0..DEPTH-1
module rom_lector #(
  parameter int unsigned AW    = 8,
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 11
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inicio,
  input  logic [AW-1:0] dir_inicio,
  input  logic [7:0]    longitud,
  output logic [AW-1:0] direccion,
  input  logic [DW-1:0] dato_rom,
  output logic [DW-1:0] dato_out,
  output logic          valido,
  input  logic          listo,
  output logic          ocupado,
  output logic          fin,
  output logic [15:0]   suma,
  output logic          error
);

  localparam int unsigned LW = 8;
  localparam int unsigned SW = 16;
  localparam logic [AW-1:0] ULTIMA = AW'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, LEER, DRENAR, FIN} estado_t;

  estado_t       estado, estado_nxt;
  logic [AW-1:0] sig_dir;
  logic [LW-1:0] restantes;
  logic          lect_a;    // address registered, ROM has not sampled it yet
  logic          lect_b;    // word present on dato_rom, waiting to enter the buffer
  logic [1:0]    cnt, cnt_nxt;
  logic [DW-1:0] buf1, dato_nxt, buf1_nxt;

  logic          acepta, fuera, emite, pop, entra;
  logic [2:0]    ocupacion;
  logic [AW-1:0] dir_emit;

  function automatic logic [AW-1:0] inc_dir(input logic [AW-1:0] a);
    return (a == ULTIMA) ? '0 : a + AW'(1);
  endfunction

  // Handshake and credit accounting. A word stalled on dato_rom is kept there by not
  // moving direccion (the ROM keeps re-reading the same address), so the ROM output
  // acts as a third storage slot next to the 2-entry buffer; this is what lets the
  // 2-cycle read loop sustain one beat per cycle.
  always_comb begin
    pop       = valido & listo;
    entra     = lect_b & ~((cnt == 2'd2) & ~pop);
    ocupacion = 3'(cnt) + 3'(lect_a) + 3'(lect_b) - 3'(pop);
    acepta    = (estado == IDLE) & inicio;
    fuera     = (dir_inicio > ULTIMA);
    dir_emit  = (estado == IDLE) ? dir_inicio : sig_dir;
  end

  // Next-state logic and read issue.
  always_comb begin
    estado_nxt = estado;
    emite      = 1'b0;
    case (estado)
      IDLE: begin
        if (inicio) begin
          if (fuera || (longitud == '0)) begin
            estado_nxt = FIN;
          end else begin
            emite      = 1'b1;
            estado_nxt = (longitud == LW'(1)) ? DRENAR : LEER;
          end
        end
      end
      LEER: begin
        if (ocupacion < 3'd3) begin
          emite = 1'b1;
          if (restantes == LW'(1)) estado_nxt = DRENAR;
        end
      end
      DRENAR: begin
        if (!lect_a && !lect_b && (cnt == 2'd0)) estado_nxt = FIN;
      end
      FIN:     estado_nxt = IDLE;
      default: estado_nxt = IDLE;
    endcase
  end

  // Output buffer next state; dato_out is the head entry, buf1 the second one.
  always_comb begin
    cnt_nxt  = cnt;
    dato_nxt = dato_out;
    buf1_nxt = buf1;
    case ({entra, pop})
      2'b10: begin
        if (cnt == 2'd0) dato_nxt = dato_rom;
        else             buf1_nxt = dato_rom;
        cnt_nxt = cnt + 2'd1;
      end
      2'b01: begin
        dato_nxt = buf1;
        cnt_nxt  = cnt - 2'd1;
      end
      2'b11: begin
        if (cnt == 2'd1) begin
          dato_nxt = dato_rom;
        end else begin
          dato_nxt = buf1;
          buf1_nxt = dato_rom;
        end
      end
      default: ;
    endcase
  end

  // State, pipeline and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado    <= IDLE;
      direccion <= '0;
      sig_dir   <= '0;
      restantes <= '0;
      lect_a    <= 1'b0;
      lect_b    <= 1'b0;
      cnt       <= 2'd0;
      dato_out  <= '0;
      buf1      <= '0;
      valido    <= 1'b0;
      ocupado   <= 1'b0;
      fin       <= 1'b0;
      suma      <= '0;
      error     <= 1'b0;
    end else begin
      estado  <= estado_nxt;
      fin     <= (estado_nxt == FIN);
      ocupado <= (estado_nxt != IDLE);
      if (emite) begin
        direccion <= dir_emit;
        sig_dir   <= inc_dir(dir_emit);
      end
      if (acepta)     restantes <= longitud - LW'(1);
      else if (emite) restantes <= restantes - LW'(1);
      lect_a   <= emite;
      lect_b   <= lect_a | (lect_b & ~entra);
      cnt      <= cnt_nxt;
      dato_out <= dato_nxt;
      buf1     <= buf1_nxt;
      valido   <= (cnt_nxt != 2'd0);
      if (acepta)   suma <= '0;
      else if (pop) suma <= suma + SW'(dato_out);
      if (acepta)   error <= fuera;
    end
  end

endmodule

// File: tb/tb_rom_lector.sv
// Bench for rom_lector: models the srom, runs directed table sweeps, a reset-mid-sweep
// sequence and randomized sweeps, checking beats, sums and flags against a reference.
module tb_rom_lector;

  localparam int unsigned AW    = 8;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 11;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          inicio;
  logic [AW-1:0] dir_inicio;
  logic [7:0]    longitud;
  logic [AW-1:0] direccion;
  logic [DW-1:0] dato_rom;
  logic [DW-1:0] dato_out;
  logic          valido;
  logic          listo;
  logic          ocupado;
  logic          fin;
  logic [15:0]   suma;
  logic          error;

  rom_lector #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .inicio(inicio), .dir_inicio(dir_inicio),
    .longitud(longitud), .direccion(direccion), .dato_rom(dato_rom),
    .dato_out(dato_out), .valido(valido), .listo(listo), .ocupado(ocupado),
    .fin(fin), .suma(suma), .error(error)
  );

  always #5 clk = ~clk;

  // Synchronous ROM: samples direccion on the rising edge, data valid after it.
  logic [DW-1:0] rom [0:255];
  always @(posedge clk) dato_rom <= rom[direccion];

  int ref_words[DEPTH] = '{90, 80, 70, 60, 50, 40, 30, 20, 10, 1, 100};

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d required %0d", nm, got, exp);
  endtask

  typedef struct {
    int    d;
    int    l;
    int    mode;     // 0: listo high, 1: listo 1,0,0,1 pattern, 2: random listo
    bit    inj;      // pulse a second inicio mid-sweep
    int    exp_sum;
    bit    exp_err;
  } vec_t;

  // One sweep: drive, observe the stream and compare with the reference model.
  task automatic sweep(input int d, input int l, input int mode, input bit inj,
                       input int tbl_sum, input string tag);
    int  exp_q[$];
    int  got_q[$];
    int  dir_q[$];
    int  exp_sum, first, x_first, x_last, fin_cyc, stab, fins, ocup_fin;
    bit  exp_err, done, prev_stall;
    int  prev_dat;
    exp_err = (d >= DEPTH);
    exp_sum = 0;
    if (!exp_err)
      for (int i = 0; i < l; i++) begin
        exp_q.push_back(ref_words[(d + i) % DEPTH]);
        exp_sum += ref_words[(d + i) % DEPTH];
      end
    first = -1; x_first = -1; x_last = -1; fin_cyc = -1;
    stab = 0; fins = 0; ocup_fin = 0; done = 1'b0; prev_stall = 1'b0; prev_dat = 0;

    @(negedge clk);
    dir_inicio = AW'(d);
    longitud   = 8'(l);
    inicio     = 1'b1;
    @(negedge clk);
    inicio = 1'b0;
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      case (mode)
        0:       listo = 1'b1;
        1:       listo = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        default: listo = 1'($urandom_range(0, 1));
      endcase
      if (inj) begin
        if (cyc == 3) begin
          inicio = 1'b1; dir_inicio = AW'(5); longitud = 8'd2;
        end else begin
          inicio = 1'b0;
        end
      end
      if (prev_stall && (!valido || (int'(dato_out) != prev_dat))) stab++;
      if (valido && first < 0) first = cyc;
      if (valido && listo) begin
        got_q.push_back(int'(dato_out));
        if (x_first < 0) x_first = cyc;
        x_last = cyc;
      end
      prev_stall = valido && !listo;
      prev_dat   = int'(dato_out);
      if (cyc < 16) dir_q.push_back(int'(direccion));
      if (fin) begin
        fins++; fin_cyc = cyc; ocup_fin = int'(ocupado); done = 1'b1;
      end
      @(negedge clk);
    end
    inicio = 1'b0;

    chk({tag, " fin_seen"}, fins, 1);
    chk({tag, " fin_one_cycle"}, int'(fin), 0);
    chk({tag, " ocupado_at_fin"}, ocup_fin, 1);
    chk({tag, " ocupado_after"}, int'(ocupado), 0);
    chk({tag, " valido_after"}, int'(valido), 0);
    chk({tag, " beat_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s beat%0d", tag, i), got_q[i], exp_q[i]);
    chk({tag, " suma"}, int'(suma), exp_sum);
    if (tbl_sum >= 0) chk({tag, " suma_table"}, int'(suma), tbl_sum);
    chk({tag, " error"}, int'(error), int'(exp_err));
    chk({tag, " stall_stable"}, stab, 0);
    if (exp_q.size() > 0) begin
      chk({tag, " first_valid_cycle"}, first, 2);
      if (mode == 0) begin
        chk({tag, " back_to_back"}, x_last - x_first, exp_q.size() - 1);
        for (int i = 0; i < l && i < 8; i++)
          chk($sformatf("%s direccion%0d", tag, i), dir_q[i], (d + i) % DEPTH);
      end
    end else begin
      chk({tag, " no_valido"}, first, -1);
      chk({tag, " fin_cycle"}, fin_cyc, 0);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " direccion"}, int'(direccion), 0);
    chk({tag, " dato_out"}, int'(dato_out), 0);
    chk({tag, " valido"}, int'(valido), 0);
    chk({tag, " ocupado"}, int'(ocupado), 0);
    chk({tag, " fin"}, int'(fin), 0);
    chk({tag, " suma"}, int'(suma), 0);
    chk({tag, " error"}, int'(error), 0);
  endtask

  vec_t tbl[6];

  initial begin
    int n;
    for (int i = 0; i < 256; i++) rom[i] = '0;
    for (int i = 0; i < DEPTH; i++) rom[i] = DW'(ref_words[i]);

    tbl[0] = '{d: 0,  l: 11, mode: 0, inj: 1'b0, exp_sum: 551, exp_err: 1'b0};
    tbl[1] = '{d: 9,  l: 4,  mode: 0, inj: 1'b0, exp_sum: 271, exp_err: 1'b0};
    tbl[2] = '{d: 0,  l: 11, mode: 1, inj: 1'b0, exp_sum: 551, exp_err: 1'b0};
    tbl[3] = '{d: 0,  l: 0,  mode: 0, inj: 1'b0, exp_sum: 0,   exp_err: 1'b0};
    tbl[4] = '{d: 11, l: 5,  mode: 0, inj: 1'b0, exp_sum: 0,   exp_err: 1'b1};
    tbl[5] = '{d: 0,  l: 11, mode: 0, inj: 1'b1, exp_sum: 551, exp_err: 1'b0};

    rst_n = 1'b0; inicio = 1'b0; dir_inicio = '0; longitud = '0; listo = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++)
      sweep(tbl[i].d, tbl[i].l, tbl[i].mode, tbl[i].inj, tbl[i].exp_sum,
            $sformatf("vec%0d", i));
    chk("vec4 error_sticky_cleared", int'(error), int'(tbl[5].exp_err));

    // Reset after the 3rd beat of a full sweep, then a fresh sweep from 2/3.
    @(negedge clk);
    dir_inicio = '0; longitud = 8'd11; inicio = 1'b1; listo = 1'b1;
    @(negedge clk);
    inicio = 1'b0;
    n = 0;
    for (int cyc = 0; cyc < 50 && n < 3; cyc++) begin
      if (valido && listo) n++;
      @(negedge clk);
    end
    chk("midrst beats_before_reset", n, 3);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midrst");
    @(negedge clk);
    chk("midrst no_fin", int'(fin), 0);
    rst_n = 1'b1;
    @(negedge clk);
    sweep(2, 3, 0, 1'b0, 180, "after_rst");

    for (int r = 0; r < 25; r++) begin
      int d, l, m;
      d = int'($urandom_range(0, 12));
      l = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 24));
      m = int'($urandom_range(0, 2));
      sweep(d, l, m, 1'b0, -1, $sformatf("rnd%0d", r));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
